keypad_hex_entry: RTL

//  Input-side partner of the 7-segment scan driver: scans a 4x4 hex matrix keypad by

---
 rtl/keypad_hex_entry_if.sv | 22 ++
 rtl/keypad_hex_entry.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/keypad_hex_entry_if.sv
// Keypad entry bus: keypad pins, clear request and the decoded key/operand outputs.
// The master side (test top or bench) drives the rows and clear; the slave is the scanner.
interface keypad_hex_entry_if;
   logic [3:0]  row_n;
   logic        clear;
   logic [3:0]  col_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [31:0] value;
   logic [3:0]  digit_count;
   logic        full;

   modport master (
      output row_n, clear,
      input  col_n, key_valid, key_code, value, digit_count, full
   );

   modport slave (
      input  row_n, clear,
      output col_n, key_valid, key_code, value, digit_count, full
   );
endinterface

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: scans a 4x4 active-low hex keypad, debounces whole-frame results
// and shifts each accepted digit into a 32-bit operand register.
module keypad_hex_entry #(
   parameter int SCAN_DIV        = 260000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic              clock,
   input  logic              rst,
   keypad_hex_entry_if.slave bus
);
   localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [3:0]    DF        = 4'(DEBOUNCE_FRAMES);
   localparam logic [4:0]    NONE      = 5'h10;

   typedef enum logic {IDLE, HELD} state_t;

   state_t        state, state_next;
   logic [3:0]    row_s1, row_s2;
   logic [CW-1:0] scan_cnt;
   logic [1:0]    col_idx;
   logic          scan_tick, frame_end;
   logic [2:0]    col_hits, hits_sum;
   logic [1:0]    col_row, frame_hits, hits_merged;
   logic [3:0]    frame_code, code_merged;
   logic [4:0]    cand, prev_cand;
   logic [3:0]    dcnt, dcnt_next;
   logic          stable;
   logic          key_valid, key_valid_next;
   logic [3:0]    key_code, key_code_next;
   logic [31:0]   value;
   logic [3:0]    digit_count;
   logic          full;

   assign scan_tick = (scan_cnt == SCAN_LAST);
   assign frame_end = scan_tick && (col_idx == 2'd3);

   // Rows are synchronised first; the scan window is long enough to absorb the 2-cycle lag.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         row_s1   <= 4'hF;
         row_s2   <= 4'hF;
         scan_cnt <= '0;
         col_idx  <= 2'd0;
      end else begin
         row_s1 <= bus.row_n;
         row_s2 <= row_s1;
         if (scan_tick) begin
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      col_hits = 3'd0;
      col_row  = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!row_s2[r]) begin
            col_hits = col_hits + 3'd1;
            col_row  = 2'(r);
         end
      end
   end

   // Hit count saturates at 2 so any multi-press in the frame collapses to NONE.
   always_comb begin
      hits_sum    = ((col_idx == 2'd0) ? 3'd0 : {1'b0, frame_hits}) + col_hits;
      hits_merged = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
      if (col_hits == 3'd1)
         code_merged = {col_row, col_idx};
      else
         code_merged = (col_idx == 2'd0) ? 4'd0 : frame_code;
      cand      = (hits_merged == 2'd1) ? {1'b0, code_merged} : NONE;
      dcnt_next = 4'd1;
      if (cand == prev_cand)
         dcnt_next = (dcnt >= DF) ? DF : dcnt + 4'd1;
      stable = (dcnt_next == DF);
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         frame_hits <= 2'd0;
         frame_code <= 4'd0;
         prev_cand  <= NONE;
         dcnt       <= 4'd0;
      end else if (scan_tick) begin
         frame_hits <= hits_merged;
         frame_code <= code_merged;
         if (frame_end) begin
            prev_cand <= cand;
            dcnt      <= dcnt_next;
         end
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
      end else begin
         state     <= state_next;
         key_valid <= key_valid_next;
         key_code  <= key_code_next;
      end
   end

   // One pulse per press: a key is reported from IDLE only, and HELD waits for a stable NONE.
   always_comb begin
      state_next     = state;
      key_valid_next = 1'b0;
      key_code_next  = key_code;
      case (state)
         IDLE: begin
            if (frame_end && stable && (cand != NONE)) begin
               key_valid_next = 1'b1;
               key_code_next  = cand[3:0];
               state_next     = HELD;
            end
         end
         HELD: begin
            if (frame_end && stable && (cand == NONE))
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         value       <= 32'd0;
         digit_count <= 4'd0;
         full        <= 1'b0;
      end else if (bus.clear) begin
         value       <= 32'd0;
         digit_count <= 4'd0;
         full        <= 1'b0;
      end else if (key_valid && !full) begin
         value       <= {value[27:0], key_code};
         digit_count <= digit_count + 4'd1;
         full        <= (digit_count == 4'd7);
      end
   end

   always_comb begin
      case (col_idx)
         2'd0:    bus.col_n = 4'b1110;
         2'd1:    bus.col_n = 4'b1101;
         2'd2:    bus.col_n = 4'b1011;
         default: bus.col_n = 4'b0111;
      endcase
   end

   assign bus.key_valid   = key_valid;
   assign bus.key_code    = key_code;
   assign bus.value       = value;
   assign bus.digit_count = digit_count;
   assign bus.full        = full;
endmodule
